// File: rtl/wishbone_master_pkg.sv
// Shared types and default sizing for the single-transfer Wishbone master.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wishbone_master_pkg;

   localparam int unsigned DEF_ADDR_W  = 4;
   localparam int unsigned DEF_DATA_W  = 8;
   localparam int unsigned DEF_TIMEOUT = 255;

   // Transaction sequencer states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      DONE = 2'd2
   } wb_state_e;

endpackage

// File: rtl/wb_timeout_counter.sv
// Watchdog for the bus phase: counts enabled cycles and flags the last allowed one.
// Latency: expired is combinational from the count; the count updates on the clock.
// Backpressure: none; TIMEOUT=0 keeps expired low forever.
module wb_timeout_counter #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned       CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TIMEOUT - 1);
   localparam bit                WD_ON = (TIMEOUT != 0);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             at_last;

   // The count holds the number of bus cycles already waited; the edge that
   // sees LAST waited cycles is the TIMEOUT-th sampling edge.
   assign at_last = (cnt_q == LAST);
   assign expired = WD_ON && enable && at_last;

   // Next count: clear wins, saturate at LAST so a disabled watchdog never wraps
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && !at_last) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Count register, forced to zero by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/wishbone_master.sv
// Single-transfer Wishbone classic master: one start pulse -> one bus cycle -> one done pulse.
// Latency: cyc_o one edge after start; done in the cycle after ack_i (or watchdog) is sampled.
// Backpressure: start is ignored while busy (no queueing); the slave stalls via ack_i.
module wishbone_master
   import wishbone_master_pkg::*;
#(
   parameter int unsigned ADDR_W  = DEF_ADDR_W,
   parameter int unsigned DATA_W  = DEF_DATA_W,
   parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [ADDR_W-1:0] adr_o,
   output logic [DATA_W-1:0] dat_o,
   input  logic [DATA_W-1:0] dat_i,
   output logic              we_o,
   output logic              cyc_o,
   output logic              stb_o,
   input  logic              ack_i,
   output logic [DATA_W-1:0] data_o,
   output logic              done
);

   wb_state_e         state_q;
   logic [ADDR_W-1:0] adr_q;
   logic [DATA_W-1:0] dat_q;
   logic [DATA_W-1:0] data_q;
   logic              we_q;
   logic              cyc_q;
   logic              stb_q;
   logic              done_q;
   logic              wd_expired;

   // Watchdog only runs while a bus cycle is open and restarts from zero otherwise
   wb_timeout_counter #(
      .TIMEOUT (TIMEOUT)
   ) u_wd (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (state_q != BUS),
      .enable  (state_q == BUS),
      .expired (wd_expired)
   );

   // Sequencer with registered bus signals; ack_i and start only matter in their own state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         adr_q   <= '0;
         dat_q   <= '0;
         data_q  <= '0;
         we_q    <= 1'b0;
         cyc_q   <= 1'b0;
         stb_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  adr_q   <= addr_i;
                  dat_q   <= data_i;
                  we_q    <= we_i;
                  cyc_q   <= 1'b1;
                  stb_q   <= 1'b1;
                  state_q <= BUS;
               end
            end
            BUS: begin
               // An ack on the watchdog's last edge still completes the transfer
               if (ack_i) begin
                  cyc_q   <= 1'b0;
                  stb_q   <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
                  if (!we_q) begin
                     data_q <= dat_i;
                  end
               end else if (wd_expired) begin
                  cyc_q   <= 1'b0;
                  stb_q   <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               cyc_q   <= 1'b0;
               stb_q   <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign adr_o  = adr_q;
   assign dat_o  = dat_q;
   assign we_o   = we_q;
   assign cyc_o  = cyc_q;
   assign stb_o  = stb_q;
   assign data_o = data_q;
   assign done   = done_q;

endmodule

// File: tb/tb_wishbone_master.sv
// Randomised transaction bench for wishbone_master with a transaction-level expectation model.
// Latency: expectations are set one step after each clock edge and compared on the falling edge.
// Backpressure: the bench slave chooses the ack delay per transfer, including never.
module tb_wishbone_master;

   localparam int AW = 4;
   localparam int DW = 8;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          we_i = 1'b0;
   logic [AW-1:0] addr_i = '0;
   logic [DW-1:0] data_i = '0;
   logic [DW-1:0] dat_i = '0;
   logic          ack_i = 1'b0;
   logic [AW-1:0] adr_o;
   logic [DW-1:0] dat_o;
   logic          we_o;
   logic          cyc_o;
   logic          stb_o;
   logic [DW-1:0] data_o;
   logic          done;

   int tests = 0;
   int fails = 0;

   // model_mem tracks what completed writes must have produced; slave_mem is what the DUT really wrote
   logic [DW-1:0] model_mem [16];
   logic [DW-1:0] slave_mem [16];

   logic          exp_cyc = 1'b0;
   logic          exp_we = 1'b0;
   logic          exp_done = 1'b0;
   logic [AW-1:0] exp_adr = '0;
   logic [DW-1:0] exp_dat = '0;
   logic [DW-1:0] exp_data_o = '0;
   bit            chk_en = 1'b0;
   int            done_cnt = 0;
   int            cyc_hi = 0;
   int            lat = 0;
   int            bus_n = 0;

   wishbone_master #(
      .ADDR_W  (AW),
      .DATA_W  (DW),
      .TIMEOUT (TO)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .we_i   (we_i),
      .addr_i (addr_i),
      .data_i (data_i),
      .adr_o  (adr_o),
      .dat_o  (dat_o),
      .dat_i  (dat_i),
      .we_o   (we_o),
      .cyc_o  (cyc_o),
      .stb_o  (stb_o),
      .ack_i  (ack_i),
      .data_o (data_o),
      .done   (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison of all outputs against the model
   always @(negedge clk) begin
      if (chk_en) begin
         chk("cyc_o", 32'(cyc_o), 32'(exp_cyc));
         chk("stb_o", 32'(stb_o), 32'(exp_cyc));
         chk("we_o", 32'(we_o), 32'(exp_we));
         chk("adr_o", 32'(adr_o), 32'(exp_adr));
         chk("dat_o", 32'(dat_o), 32'(exp_dat));
         chk("data_o", 32'(data_o), 32'(exp_data_o));
         chk("done", 32'(done), 32'(exp_done));
         if (done === 1'b1) done_cnt++;
         if (cyc_o === 1'b1) cyc_hi++;
      end
   end

   // One transfer. Called just after a rising edge with the DUT idle.
   // ack_at: which bus-phase sampling edge sees ack (0 = slave never acks).
   task automatic run_txn(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int ack_at, input bit trailing, input bit noise_start);
      bit ack_now;
      bit ended;
      ended    = 1'b0;
      done_cnt = 0;
      cyc_hi   = 0;
      bus_n    = 0;
      start = 1'b1; we_i = we; addr_i = a; data_i = d; ack_i = 1'b0;
      @(posedge clk); #1;
      start = 1'b0; we_i = 1'($urandom); addr_i = AW'($urandom); data_i = DW'($urandom);
      exp_cyc = 1'b1; exp_we = we; exp_adr = a; exp_dat = d; exp_done = 1'b0;
      for (int k = 1; k <= 64; k++) begin
         ack_now = (k == ack_at);
         bus_n++;
         ack_i = ack_now;
         if (ack_now && !we_o) dat_i = slave_mem[adr_o];
         else                  dat_i = DW'($urandom);
         if (ack_now && we_o) slave_mem[adr_o] = dat_o;
         start = noise_start && ($urandom_range(0, 1) == 1);
         @(posedge clk); #1;
         start = 1'b0;
         if (ack_now || k == TO) begin
            exp_cyc  = 1'b0;
            exp_done = 1'b1;
            if (ack_now && !we) exp_data_o = model_mem[a];
            if (ack_now && we)  model_mem[a] = d;
            ended = 1'b1;
            break;
         end
      end
      chk("bus_phase_ended", 32'(ended), 32'd1);
      lat = 1 + bus_n;
      // DONE cycle: optional trailing ack and a stray start, both must be ignored
      ack_i = trailing;
      start = noise_start;
      @(posedge clk); #1;
      exp_done = 1'b0;
      start = 1'b0;
      ack_i = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         ack_i = 1'($urandom);
         dat_i = DW'($urandom);
         @(posedge clk); #1;
      end
      ack_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_time_limit: simulation did not finish");
      $fatal(1, "time limit");
   end

   initial begin
      for (int i = 0; i < 16; i++) begin
         model_mem[i] = DW'($urandom);
         slave_mem[i] = model_mem[i];
      end
      model_mem[3] = 8'h55;
      slave_mem[3] = 8'h55;

      // Reset state
      #1;
      chk("rst_cyc", 32'(cyc_o), 32'd0);
      chk("rst_stb", 32'(stb_o), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_data_o", 32'(data_o), 32'd0);
      chk_en = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;

      // Write 0xAA to address 5 straight after reset release; slave acks one cycle after stb
      run_txn(1'b1, 4'd5, 8'hAA, 2, 1'b0, 1'b0);
      chk("wr_slave_mem5", 32'(slave_mem[5]), 32'hAA);
      chk("wr_data_o_kept", 32'(data_o), 32'h00);
      chk("wr_done_pulses", done_cnt, 1);
      chk("wr_latency", lat, 3);

      // Read it back
      run_txn(1'b0, 4'd5, 8'h00, 2, 1'b0, 1'b0);
      chk("rd5_data_o", 32'(data_o), 32'hAA);
      chk("rd5_done_pulses", done_cnt, 1);

      // Preloaded read with a trailing ack held through DONE
      run_txn(1'b0, 4'd3, 8'h00, 1, 1'b1, 1'b0);
      idle_cycles(3);
      chk("rd3_data_o", 32'(data_o), 32'h55);
      chk("rd3_done_pulses", done_cnt, 1);

      // start pulsed while busy
      run_txn(1'b0, 4'd3, 8'h00, 5, 1'b0, 1'b1);
      idle_cycles(2);
      chk("busy_start_done_pulses", done_cnt, 1);

      // Slave never acks: watchdog closes the cycle after TO bus cycles
      run_txn(1'b0, 4'd7, 8'h00, 0, 1'b0, 1'b0);
      chk("to_cyc_len", cyc_hi, 8);
      chk("to_done_pulses", done_cnt, 1);
      chk("to_data_o_kept", 32'(data_o), 32'h55);

      // Reset in the middle of a bus cycle
      done_cnt = 0;
      start = 1'b1; we_i = 1'b0; addr_i = 4'd2; data_i = 8'h11;
      @(posedge clk); #1;
      start = 1'b0;
      exp_cyc = 1'b1; exp_we = 1'b0; exp_adr = 4'd2; exp_dat = 8'h11;
      @(posedge clk); #3;
      rst_n = 1'b0;
      exp_cyc = 1'b0; exp_we = 1'b0; exp_adr = '0; exp_dat = '0; exp_data_o = '0; exp_done = 1'b0;
      #1;
      chk("arst_cyc", 32'(cyc_o), 32'd0);
      chk("arst_stb", 32'(stb_o), 32'd0);
      chk("arst_done", 32'(done), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("arst_no_done", done_cnt, 0);
      run_txn(1'b1, 4'd9, 8'h3C, 3, 1'b0, 1'b0);
      chk("post_rst_mem9", 32'(slave_mem[9]), 32'h3C);
      chk("post_rst_done_pulses", done_cnt, 1);
      run_txn(1'b0, 4'd1, 8'h00, 0, 1'b0, 1'b0);
      chk("post_rst_to_len", cyc_hi, 8);

      // Randomised transfers, some long enough to hit the watchdog
      for (int t = 0; t < 40; t++) begin
         run_txn(1'($urandom), AW'($urandom), DW'($urandom), $urandom_range(0, 10),
                 1'($urandom), 1'($urandom));
         chk("rand_done_pulses", done_cnt, 1);
         idle_cycles($urandom_range(0, 3));
      end
      for (int i = 0; i < 16; i++) begin
         chk("final_mem", 32'(slave_mem[i]), 32'(model_mem[i]));
      end

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/wishbone_master.md
WISHBONE_MASTER -- requirements
Module: wishbone_master

Interface
REQ-001 Parameter ADDR_W, default 4: width of addr_i and adr_o.
REQ-002 Parameter DATA_W, default 8: width of data_i, dat_o, dat_i and data_o.
REQ-003 Parameter TIMEOUT, default 255: maximum cycles to wait for ack_i; 0 disables the watchdog.
REQ-004 clk  in  1  clock; all logic on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  one-cycle request pulse to launch a transaction.
REQ-007 we_i  in  1  transaction type: 1 = write, 0 = read.
REQ-008 addr_i  in  ADDR_W  transaction address.
REQ-009 data_i  in  DATA_W  write data.
REQ-010 adr_o  out  ADDR_W  Wishbone address.
REQ-011 dat_o  out  DATA_W  Wishbone write data.
REQ-012 dat_i  in  DATA_W  Wishbone read data.
REQ-013 we_o  out  1  Wishbone write enable.
REQ-014 cyc_o  out  1  Wishbone cycle.
REQ-015 stb_o  out  1  Wishbone strobe.
REQ-016 ack_i  in  1  Wishbone acknowledge.
REQ-017 data_o  out  DATA_W  captured read data.
REQ-018 done  out  1  one-cycle transaction-complete pulse.

Function
REQ-019 The FSM SHALL have three states: IDLE, BUS and DONE; all outputs SHALL be registered.
REQ-020 In IDLE, start=1 at a clock edge SHALL latch addr_i, data_i and we_i into adr_o, dat_o and we_o, SHALL set cyc_o=stb_o=1, and SHALL move the FSM to BUS.
REQ-021 In BUS, cyc_o, stb_o, adr_o, dat_o and we_o SHALL stay stable until ack_i is sampled high.
REQ-022 When ack_i is sampled high in BUS, the block SHALL clear cyc_o and stb_o on that edge, SHALL load data_o from dat_i if we_o=0, and SHALL move the FSM to DONE.
REQ-023 On a write, data_o SHALL keep its previous value.
REQ-024 DONE SHALL assert done for exactly one cycle, then return to IDLE; done SHALL be 0 in all other states.
REQ-025 ack_i SHALL be ignored in IDLE and DONE; a trailing ack_i that stays high one cycle after cyc_o falls SHALL have no effect.
REQ-026 start SHALL be ignored in BUS and DONE; there is no queueing.
REQ-027 Minimum latency: start edge to cyc_o high is 1 cycle; with a slave that acks 1 cycle after seeing stb, done SHALL be high 3 cycles after the start edge.
REQ-028 If TIMEOUT>0 and ack_i has not been seen within TIMEOUT cycles in BUS, the block SHALL drop cyc_o and stb_o, SHALL leave data_o unchanged, and SHALL go to DONE (done still pulses).
REQ-029 we_o, adr_o and dat_o SHALL hold their last values after the cycle ends.

Reset
REQ-030 rst_n=0 SHALL asynchronously force: state IDLE; cyc_o, stb_o, we_o and done to 0; adr_o, dat_o and data_o to 0; watchdog counter to 0.
REQ-031 Reset asserted during BUS SHALL abort the cycle immediately, with no done pulse.
REQ-032 After rst_n is released, the first start SHALL be accepted on the next edge.

Structure
REQ-033 A package wishbone_master_pkg SHALL hold the state enum (IDLE, BUS, DONE) and the default width constants.
REQ-034 The watchdog SHALL be one sub-module, wb_timeout_counter, with ports clear, enable and expired; everything else is a single FSM module.

Verification
REQ-035 Write: we_i=1, addr_i=5, data_i=0xAA, start pulse -> cyc_o/stb_o/we_o high with adr_o=5, dat_o=0xAA; slave memory[5]=0xAA; one done pulse; data_o unchanged.
REQ-036 Read after write: we_i=0, addr_i=5, start pulse -> data_o=0xAA when done pulses; cyc_o low in the done cycle.
REQ-037 Read of preloaded memory[3]=0x55 -> data_o=0x55; a trailing ack_i in DONE/IDLE causes no second done pulse.
REQ-038 start pulsed again while in BUS -> ignored; exactly one done pulse.
REQ-039 Slave never acks, TIMEOUT=8 -> cyc_o drops 8 cycles after entering BUS; done pulses; data_o unchanged.
REQ-040 rst_n driven low mid-BUS -> cyc_o, stb_o and done go to 0 immediately; FSM in IDLE; the next transaction completes normally.
